// File: rtl/encoder_8to3_seq.sv
// Sequential 8-to-3 encoder: captures a request vector and streams out the index of every set bit.
// Optional feature macro ENC_ZERO_ERR_EN adds an ERR pulse for zero or multi-hot vectors.
module encoder_8to3_seq #(
    parameter int N         = 8,
    parameter int M         = 3,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         IN_VLD,
    output logic         IN_RDY,
    input  logic [N-1:0] I,
    output logic         O_VLD,
    input  logic         O_RDY,
    output logic [M-1:0] O,
    output logic         O_LAST
`ifdef ENC_ZERO_ERR_EN
    ,
    output logic         ERR
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [N-1:0]   pend_q;
    logic [N-1:0]   pend_d;

    logic [M-1:0]   idx_s;
    logic           one_hot_s;
    logic           scan_s;
    logic           o_vld_s;
    logic           o_last_s;
    logic           in_rdy_s;
    logic           accept_s;
    logic           out_hs_s;

    // Priority scan over pend: the last match in iteration order wins.
    always_comb begin
        idx_s = {M{1'b0}};
        if (MSB_FIRST) begin
            for (int k = 0; k < N; k++) begin
                idx_s = pend_q[k] ? M'(k) : idx_s;
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                idx_s = pend_q[k] ? M'(k) : idx_s;
            end
        end
    end

    // Handshake qualifiers; outputs are forced quiet while RST is held so no transfer can occur.
    always_comb begin
        one_hot_s = (pend_q != {N{1'b0}}) && ((pend_q & (pend_q - N'(1))) == {N{1'b0}});
        scan_s    = (state_q == ST_SCAN);
        o_vld_s   = !RST && scan_s;
        o_last_s  = o_vld_s && one_hot_s;
        out_hs_s  = o_vld_s && O_RDY;
        in_rdy_s  = !RST && (!scan_s || (out_hs_s && o_last_s));
        accept_s  = IN_VLD && in_rdy_s;
    end

    // Next-state and pending-vector update.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        if (RST) begin
            state_d = ST_IDLE;
            pend_d  = {N{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_SCAN: begin
                    if (out_hs_s) begin
                        pend_d  = pend_q & ~(N'(1) << idx_s);
                        state_d = o_last_s ? ST_IDLE : ST_SCAN;
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    pend_d  = {N{1'b0}};
                end
            endcase
            // A new vector may land in the same cycle the previous last index leaves.
            if (accept_s) begin
                pend_d  = I;
                state_d = (I != {N{1'b0}}) ? ST_SCAN : ST_IDLE;
            end else begin
                pend_d  = pend_d;
            end
        end
    end

    // State and pending registers.
    always_ff @(posedge CLK) begin
        state_q <= state_d;
        pend_q  <= pend_d;
    end

    assign IN_RDY = in_rdy_s;
    assign O_VLD  = o_vld_s;
    assign O      = RST ? {M{1'b0}} : idx_s;
    assign O_LAST = o_last_s;

`ifdef ENC_ZERO_ERR_EN
    logic err_q;
    logic err_d;

    // Flag an accepted vector that is not exactly one-hot.
    always_comb begin
        if (RST) begin
            err_d = 1'b0;
        end else begin
            err_d = accept_s && ((I == {N{1'b0}}) || ((I & (I - N'(1))) != {N{1'b0}}));
        end
    end

    // Error pulse register.
    always_ff @(posedge CLK) begin
        err_q <= err_d;
    end

    assign ERR = err_q;
`endif

endmodule

// File: tb/tb_encoder_8to3_seq.sv
// Table-driven bench for encoder_8to3_seq, plus a hand sequence for the MSB-first variant.
module tb_encoder_8to3_seq;

    logic       clk;
    logic       rst;
    logic       in_vld;
    logic [7:0] in_i;
    logic       o_rdy;

    logic       rdy_a, vld_a, last_a;
    logic [2:0] o_a;
    logic       rdy_b, vld_b, last_b;
    logic [2:0] o_b;
`ifdef ENC_ZERO_ERR_EN
    logic       err_a, err_b;
`endif

    int n_checks = 0;
    int n_errors = 0;

    encoder_8to3_seq #(.N(8), .M(3), .MSB_FIRST(1'b0)) u_lsb (
        .CLK(clk), .RST(rst), .IN_VLD(in_vld), .IN_RDY(rdy_a), .I(in_i),
        .O_VLD(vld_a), .O_RDY(o_rdy), .O(o_a), .O_LAST(last_a)
`ifdef ENC_ZERO_ERR_EN
        , .ERR(err_a)
`endif
    );

    encoder_8to3_seq #(.N(8), .M(3), .MSB_FIRST(1'b1)) u_msb (
        .CLK(clk), .RST(rst), .IN_VLD(in_vld), .IN_RDY(rdy_b), .I(in_i),
        .O_VLD(vld_b), .O_RDY(o_rdy), .O(o_b), .O_LAST(last_b)
`ifdef ENC_ZERO_ERR_EN
        , .ERR(err_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] i;
        logic       ordy;
        logic       e_rdy;
        logic       e_vld;
        logic [2:0] e_o;
        logic       e_last;
        logic       e_err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic v, input logic [7:0] i, input logic ordy,
                       input logic e_rdy, input logic e_vld, input logic [2:0] e_o,
                       input logic e_last, input logic e_err);
        vec_t t;
        t.rst = r; t.vld = v; t.i = i; t.ordy = ordy;
        t.e_rdy = e_rdy; t.e_vld = e_vld; t.e_o = e_o; t.e_last = e_last; t.e_err = e_err;
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset, held with a full vector offered
        for (int k = 0; k < 3; k++) add(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        // one-hot sweep, back-to-back
        add(1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        for (int k = 1; k < 8; k++)
            add(1'b0, 1'b1, 8'(8'h01 << k), 1'b1, 1'b1, 1'b1, 3'(k - 1), 1'b1, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        // multi-hot, lowest first
        add(1'b0, 1'b1, 8'hA4, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        // backpressure with a competing vector offered
        add(1'b0, 1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) add(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        // zero vector
        add(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        // reset mid-scan
        add(1'b0, 1'b1, 8'hF0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1);
        add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        // next vector captured on the last-index handshake, refused on a non-last one
        add(1'b0, 1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h80, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

        rst = 1'b1; in_vld = 1'b0; in_i = 8'h00; o_rdy = 1'b1;
        step();
        step();

        for (int r = 0; r < tbl.size(); r++) begin
            rst = tbl[r].rst; in_vld = tbl[r].vld; in_i = tbl[r].i; o_rdy = tbl[r].ordy;
            #2;
            chk("in_rdy", r, {7'd0, rdy_a}, {7'd0, tbl[r].e_rdy});
            chk("o_vld", r, {7'd0, vld_a}, {7'd0, tbl[r].e_vld});
            chk("o", r, {5'd0, o_a}, {5'd0, tbl[r].e_o});
            chk("o_last", r, {7'd0, last_a}, {7'd0, tbl[r].e_last});
`ifdef ENC_ZERO_ERR_EN
            chk("err", r, {7'd0, err_a}, {7'd0, tbl[r].e_err});
`endif
            step();
        end

        // highest set bit first on the MSB_FIRST instance
        rst = 1'b0; in_vld = 1'b1; in_i = 8'hA4; o_rdy = 1'b1;
        #2;
        chk("msb_in_rdy", 100, {7'd0, rdy_b}, 8'd1);
        chk("msb_o_vld", 100, {7'd0, vld_b}, 8'd0);
        step();
        in_vld = 1'b0; in_i = 8'h00;
        #2;
        chk("msb_o", 101, {5'd0, o_b}, 8'd7);
        chk("msb_last", 101, {7'd0, last_b}, 8'd0);
        chk("msb_in_rdy", 101, {7'd0, rdy_b}, 8'd0);
        step();
        #2;
        chk("msb_o", 102, {5'd0, o_b}, 8'd5);
        chk("msb_last", 102, {7'd0, last_b}, 8'd0);
        step();
        #2;
        chk("msb_o", 103, {5'd0, o_b}, 8'd2);
        chk("msb_last", 103, {7'd0, last_b}, 8'd1);
        chk("msb_o_vld", 103, {7'd0, vld_b}, 8'd1);
        step();
        #2;
        chk("msb_o_vld", 104, {7'd0, vld_b}, 8'd0);
`ifdef ENC_ZERO_ERR_EN
        chk("msb_err", 104, {7'd0, err_b}, 8'd0);
`endif
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
